// File: rtl/norn_pkg.sv
// Shared definitions for the norn_bist gate cell: FSM states, function
// encodings and the golden model used by the self-test checker.
package norn_pkg;

    // Widest supported gate; the golden model works on vectors of this width.
    localparam int MAX_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] OP_NOR  = 2'd0;
    localparam logic [1:0] OP_NAND = 2'd1;
    localparam logic [1:0] OP_OR   = 2'd2;
    localparam logic [1:0] OP_AND  = 2'd3;

    // Expected gate output for vector vec of width n (upper bits of vec must be zero).
    function automatic logic golden(input logic [MAX_N-1:0] vec,
                                    input logic [1:0]       op,
                                    input int               n);
        logic [MAX_N-1:0] ones;
        logic             all_zero;
        logic             all_one;
        logic             result;
        ones     = {MAX_N{1'b1}} >> (MAX_N - n);
        all_zero = (vec == '0);
        all_one  = (vec == ones);
        case (op)
            OP_NOR:  result = all_zero;
            OP_NAND: result = !all_one;
            OP_OR:   result = !all_zero;
            default: result = all_one;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/norn_core.sv
// Combinational N-input gate: NOR, NAND, OR or AND of the operand bits.
module norn_core
    import norn_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] operand,
    input  logic [1:0]   op,
    output logic         y
);

    // Select the reduction selected by op.
    always_comb begin
        // NOTE: assigning a default before the case guarantees no latch even if an arm is missed.
        y = 1'b0;
        case (op)
            OP_NOR:  y = ~(|operand);
            OP_NAND: y = ~(&operand);
            OP_OR:   y = |operand;
            OP_AND:  y = &operand;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/norn_bist.sv
// Registered multi-function N-input gate with an exhaustive built-in self-test.
// Normal mode registers gate(func_in); a BIST run sweeps every input vector
// through the same gate, compares against the golden model and counts misses.
module norn_bist
    import norn_pkg::*;
#(
    parameter int N    = 3,
    parameter int HOLD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] func_in,
    input  logic [1:0]   op,
    input  logic         start,
    input  logic         inject_fault,
    output logic         y,
    output logic [N-1:0] vec_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count
);

    localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N-1:0]  VEC_LAST  = '1;
    localparam logic [N:0]    ERR_MAX   = {1'b1, {N{1'b0}}};

    state_e        state;
    logic [N-1:0]  vec;
    logic [HW-1:0] hold;
    logic [1:0]    op_q;
    logic          chk_q;
    logic          exp_q;
    logic          y_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [N:0]    err_q;
    logic [N:0]    err_next;
    logic [N-1:0]  operand;
    logic [1:0]    gate_op;
    logic          y_raw;

    // During a run the gate sees the sweep vector and the latched function.
    assign operand = busy_q ? vec : func_in;
    assign gate_op = busy_q ? op_q : op;

    norn_core #(.N(N)) u_core (
        .operand (operand),
        .op      (gate_op),
        .y       (y_raw)
    );

    // Error counter next value: one step per checked mismatch, saturating.
    always_comb begin
        err_next = err_q;
        if (chk_q && (y_q != exp_q) && (err_q != ERR_MAX)) begin
            err_next = err_q + 1'b1;
        end
    end

    // Output register: gate result, optionally inverted for checker self-test.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_raw ^ inject_fault;
        end
    end

    // Check pipeline: flag the last hold cycle of each vector and its expected output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_q <= 1'b0;
            exp_q <= 1'b0;
        end else begin
            chk_q <= (state == RUN) && (hold == HOLD_LAST);
            exp_q <= golden(MAX_N'(vec), op_q, N);
        end
    end

    // Sequencer FSM with registered busy/done/pass and the sweep counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            vec    <= '0;
            hold   <= '0;
            op_q   <= 2'd0;
            err_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= err_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        err_q  <= '0;
                        pass_q <= 1'b0;
                        vec    <= '0;
                        hold   <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (hold == HOLD_LAST) begin
                        hold <= '0;
                        // The final vector is held, not wrapped, while its check drains.
                        if (vec == VEC_LAST) begin
                            state <= DRAIN;
                        end else begin
                            vec <= vec + 1'b1;
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                DRAIN: begin
                    // err_next already includes the last vector's check here.
                    pass_q <= (err_next == '0);
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    vec    <= '0;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign y         = y_q;
    assign vec_out   = vec;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_norn_bist.sv
// Directed bench for norn_bist: normal-mode gate functions, BIST runs with
// HOLD=1 and HOLD=3, fault injection, ignored start/op changes and reset abort.
module tb_norn_bist;
    import norn_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] func_in;
    logic [1:0] op;
    logic       start1;
    logic       start3;
    logic       inject_fault;

    logic       y1, busy1, done1, pass1;
    logic [2:0] vec1;
    logic [3:0] err1;
    logic       y3, busy3, done3, pass3;
    logic [2:0] vec3;
    logic [3:0] err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    norn_bist #(.N(3), .HOLD(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .func_in      (func_in),
        .op           (op),
        .start        (start1),
        .inject_fault (inject_fault),
        .y            (y1),
        .vec_out      (vec1),
        .busy         (busy1),
        .done         (done1),
        .pass         (pass1),
        .err_count    (err1)
    );

    norn_bist #(.N(3), .HOLD(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .func_in      (func_in),
        .op           (op),
        .start        (start3),
        .inject_fault (inject_fault),
        .y            (y3),
        .vec_out      (vec3),
        .busy         (busy3),
        .done         (done3),
        .pass         (pass3),
        .err_count    (err3)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; func_in = 3'b000; op = OP_NOR;
        start1 = 1'b0; start3 = 1'b0; inject_fault = 1'b0;
        tick(); tick();
        checks++; if (y1 !== 1'b0)    begin errors++; $display("FAIL reset_y got=%b exp=0", y1); end
        checks++; if (vec1 !== 3'd0)  begin errors++; $display("FAIL reset_vec got=%0d exp=0", vec1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass1); end
        checks++; if (err1 !== 4'd0)  begin errors++; $display("FAIL reset_err got=%0d exp=0", err1); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3 got=%b exp=0", busy3); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        logic [1:0] ops  [8] = '{OP_NOR, OP_NOR, OP_AND, OP_AND, OP_NAND, OP_NAND, OP_OR, OP_OR};
        logic [2:0] ins  [8] = '{3'b000, 3'b010, 3'b111, 3'b110, 3'b111, 3'b110, 3'b000, 3'b010};
        logic       exps [8] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1};
        for (int i = 0; i < 8; i++) begin
            op = ops[i]; func_in = ins[i];
            tick();
            checks++;
            if (y1 !== exps[i]) begin
                errors++; $display("FAIL normal_%0d op=%0d in=%b got=%b exp=%b", i, ops[i], ins[i], y1, exps[i]);
            end
            checks++;
            if (y3 !== exps[i]) begin
                errors++; $display("FAIL normal3_%0d op=%0d in=%b got=%b exp=%b", i, ops[i], ins[i], y3, exps[i]);
            end
        end
        func_in = 3'b000;
    endtask

    // HOLD=1 run; fault_mode 0 none, 1 held high, 2 only while vector 5 is applied.
    task automatic run_hold1(input int fault_mode, input logic exp_pass, input logic [3:0] exp_err);
        op = OP_NOR; start1 = 1'b1; inject_fault = (fault_mode == 1);
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (fault_mode == 2) inject_fault = (c == 6);
            if (c <= 8) begin
                checks++;
                if (vec1 !== 3'(c - 1)) begin
                    errors++; $display("FAIL bist_vec c=%0d got=%0d exp=%0d", c, vec1, c - 1);
                end
            end
            checks++;
            if (busy1 !== (c <= 9)) begin
                errors++; $display("FAIL bist_busy c=%0d got=%b exp=%b", c, busy1, (c <= 9));
            end
            checks++;
            if (done1 !== (c == 10)) begin
                errors++; $display("FAIL bist_done c=%0d got=%b exp=%b", c, done1, (c == 10));
            end
            if (c >= 10) begin
                checks++;
                if (pass1 !== exp_pass) begin errors++; $display("FAIL bist_pass c=%0d got=%b exp=%b", c, pass1, exp_pass); end
                checks++;
                if (err1 !== exp_err) begin errors++; $display("FAIL bist_err c=%0d got=%0d exp=%0d", c, err1, exp_err); end
            end
            tick();
        end
        inject_fault = 1'b0;
    endtask

    task automatic test_bist_nor();
        run_hold1(0, 1'b1, 4'd0);
    endtask

    task automatic test_fault_all();
        run_hold1(1, 1'b0, 4'd8);
    endtask

    task automatic test_fault_one();
        run_hold1(2, 1'b0, 4'd1);
    endtask

    task automatic test_hold3();
        op = OP_OR; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            // A start pulse and op change mid-run must not disturb the sweep.
            if (c == 5) begin op = OP_AND; start3 = 1'b1; end
            if (c == 6) start3 = 1'b0;
            if (c == 4 || c == 24) begin
                checks++;
                if (vec3 !== ((c == 4) ? 3'd1 : 3'd7)) begin
                    errors++; $display("FAIL hold3_vec c=%0d got=%0d", c, vec3);
                end
            end
            checks++;
            if (busy3 !== (c <= 25)) begin errors++; $display("FAIL hold3_busy c=%0d got=%b exp=%b", c, busy3, (c <= 25)); end
            checks++;
            if (done3 !== (c == 26)) begin errors++; $display("FAIL hold3_done c=%0d got=%b exp=%b", c, done3, (c == 26)); end
            if (c == 26) begin
                checks++;
                if (err3 !== 4'd0) begin errors++; $display("FAIL hold3_err got=%0d exp=0", err3); end
                checks++;
                if (pass3 !== 1'b1) begin errors++; $display("FAIL hold3_pass got=%b exp=1", pass3); end
            end
            tick();
        end
        op = OP_NOR;
    endtask

    task automatic test_reset_mid_run();
        op = OP_NOR; start1 = 1'b1; inject_fault = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick(); tick();
        // Cycle 4: vectors 0 and 1 have been checked against faulted outputs.
        checks++;
        if (err1 !== 4'd2) begin errors++; $display("FAIL abort_err_before got=%0d exp=2", err1); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; inject_fault = 1'b0;
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy1); end
        checks++;
        if (err1 !== 4'd0) begin errors++; $display("FAIL abort_err got=%0d exp=0", err1); end
        for (int c = 5; c <= 12; c++) begin
            checks++;
            if (done1 !== 1'b0) begin errors++; $display("FAIL abort_done c=%0d got=%b exp=0", c, done1); end
            tick();
        end
        run_hold1(0, 1'b1, 4'd0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bist_nor();
        test_fault_all();
        test_fault_one();
        test_hold3();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
